// File: rtl/vdu_pkg.sv
// Shared constants and entry packing helpers for the VDU write buffer.
package vdu_pkg;

    localparam logic [19:0] VDU_MEM_BASE  = 20'hB8000;
    localparam logic [19:0] VDU_MEM_LIMIT = 20'hBBFFF;
    localparam logic [19:0] VDU_IO_BASE   = 20'h003D0;
    localparam logic [19:0] VDU_IO_LIMIT  = 20'h003DF;

    localparam int VDU_ENTRY_W   = 29;
    localparam int VDU_DATA_LSB  = 0;
    localparam int VDU_DATA_W    = 8;
    localparam int VDU_ADDR_LSB  = 8;
    localparam int VDU_ADDR_W    = 20;
    localparam int VDU_IS_IO_BIT = 28;

    function automatic logic addr_in_range(input logic [19:0] addr,
                                           input logic [19:0] lo,
                                           input logic [19:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic logic [VDU_ENTRY_W-1:0] pack_entry(input logic       is_io,
                                                          input logic [19:0] addr,
                                                          input logic [7:0]  data);
        return {is_io, addr, data};
    endfunction

endpackage

// File: rtl/vdu_sync_edge.sv
// Two-flop synchroniser for an asynchronous level strobe, with a history
// flop so each assertion yields a single-cycle rise pulse.
module vdu_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain plus history flop; all cleared by reset so a
    // strobe already high at release is seen as a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= strobe;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/vdu_write_buffer.sv
// Posted-write FIFO between the 8088 bus and the VDU write port: filters
// CPU strobes by address window and hands entries over valid/ready.
module vdu_write_buffer
    import vdu_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter int          AFULL_MARGIN = 2,
    parameter logic [19:0] MEM_BASE     = VDU_MEM_BASE,
    parameter logic [19:0] MEM_LIMIT    = VDU_MEM_LIMIT,
    parameter logic [19:0] IO_BASE      = VDU_IO_BASE,
    parameter logic [19:0] IO_LIMIT     = VDU_IO_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [19:0]              a,
    input  logic [7:0]               d,
    input  logic                     memw,
    input  logic                     iow,
    output logic                     cpu_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_is_io,
    output logic [19:0]              out_addr,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     collision,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    logic [VDU_ENTRY_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;

    logic          mem_rise_s;
    logic          io_rise_s;
    logic          mem_hit_s;
    logic          io_hit_s;
    logic          collide_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [LW-1:0] level_next_s;

    vdu_sync_edge u_sync_memw (
        .clk    (clk),
        .rst    (rst),
        .strobe (memw),
        .rise   (mem_rise_s)
    );

    vdu_sync_edge u_sync_iow (
        .clk    (clk),
        .rst    (rst),
        .strobe (iow),
        .rise   (io_rise_s)
    );

    // Address filtering and push/pop arbitration; a coincident I/O rise
    // always loses to the memory rise.
    always_comb begin
        mem_hit_s    = mem_rise_s & addr_in_range(a, MEM_BASE, MEM_LIMIT);
        io_hit_s     = io_rise_s & ~mem_rise_s & addr_in_range(a, IO_BASE, IO_LIMIT);
        collide_s    = mem_rise_s & io_rise_s;
        push_req_s   = mem_hit_s | io_hit_s;
        pop_s        = out_valid & out_ready;
        push_s       = push_req_s & ((level != LVL_FULL) | pop_s);
        drop_s       = push_req_s & (level == LVL_FULL) & ~pop_s;
        level_next_s = level + LW'(push_s) - LW'(pop_s);
    end

    // FIFO storage, pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            cpu_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= pack_entry(~mem_hit_s, a, d);
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level     <= level_next_s;
            out_valid <= (level_next_s != '0);
            cpu_ready <= ((DEPTH - int'(level_next_s)) > AFULL_MARGIN);
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (collide_s) begin
                collision <= 1'b1;
            end else if (clr_err) begin
                collision <= 1'b0;
            end
        end
    end

    assign out_is_io = mem_r[rd_ptr_r][VDU_IS_IO_BIT];
    assign out_addr  = mem_r[rd_ptr_r][VDU_ADDR_LSB +: VDU_ADDR_W];
    assign out_data  = mem_r[rd_ptr_r][VDU_DATA_LSB +: VDU_DATA_W];

endmodule

// File: tb/tb_vdu_write_buffer.sv
// Self-checking bench: directed scenarios plus random strobe traffic,
// compared every cycle against a queue-based model of the posted-write FIFO.
module tb_vdu_write_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] a;
    logic [7:0]  d;
    logic        memw;
    logic        iow;
    logic        cpu_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_io;
    logic [19:0] out_addr;
    logic [7:0]  out_data;
    logic [3:0]  level;
    logic        overflow;
    logic        collision;
    logic        clr_err;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    bit rand_mode   = 1'b0;

    // model state
    logic [28:0] mq[$];
    bit m_ov, m_col, m_rdy;
    int cd_mem, cd_io;
    bit prev_mem, prev_io;

    vdu_write_buffer dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .memw(memw), .iow(iow),
        .cpu_ready(cpu_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_is_io(out_is_io), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow), .collision(collision), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    function automatic bit in_mem(input logic [19:0] x);
        return (x >= 20'hB8000) && (x <= 20'hBBFFF);
    endfunction

    function automatic bit in_io(input logic [19:0] x);
        return (x >= 20'h003D0) && (x <= 20'h003DF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A strobe first seen high after a low sample yields a push two edges later.
    task automatic model_step();
        bit mem_fire, io_fire, pop, full, want_mem, want_io;
        if (rst) begin
            mq.delete();
            m_ov = 1'b0; m_col = 1'b0; m_rdy = 1'b1;
            cd_mem = 0; cd_io = 0; prev_mem = 1'b0; prev_io = 1'b0;
        end else begin
            mem_fire = (cd_mem == 1);
            io_fire  = (cd_io == 1);
            if (cd_mem != 0) cd_mem--;
            if (cd_io != 0) cd_io--;
            if (memw && !prev_mem) cd_mem = 2;
            if (iow && !prev_io) cd_io = 2;
            prev_mem = memw;
            prev_io  = iow;

            want_mem = mem_fire && in_mem(a);
            want_io  = io_fire && !mem_fire && in_io(a);
            full     = (mq.size() == DEPTH);
            pop      = (mq.size() != 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (want_mem || want_io) begin
                if (full && !pop) m_ov = 1'b1;
                else mq.push_back({want_io, a, d});
            end else if (clr_err) begin
                m_ov = 1'b0;
            end
            if ((want_mem || want_io) && full && !pop) m_ov = 1'b1;
            else if (clr_err && !((want_mem || want_io) && full && !pop)) m_ov = 1'b0;
            if (mem_fire && io_fire) m_col = 1'b1;
            else if (clr_err) m_col = 1'b0;
            m_rdy = (DEPTH - mq.size()) > 2;
        end
    endtask

    always @(posedge clk) model_step();

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", level, mq.size());
            chk("out_valid", out_valid, (mq.size() != 0));
            chk("cpu_ready", cpu_ready, m_rdy);
            chk("overflow", overflow, m_ov);
            chk("collision", collision, m_col);
            if (mq.size() != 0) begin
                chk("out_is_io", out_is_io, mq[0][28]);
                chk("out_addr", out_addr, mq[0][27:8]);
                chk("out_data", out_data, mq[0][7:0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 2) == 0);
            clr_err   = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic write_pulse(input logic m, input logic i, input logic [19:0] ad,
                               input logic [7:0] dd, input int hi);
        a = ad; d = dd; memw = m; iow = i;
        repeat (hi) tick();
        memw = 1'b0; iow = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [19:0] pick_addr(input int kind);
        logic [19:0] r;
        case (kind)
            0: r = 20'hB8000 + 20'($urandom_range(0, 32'h3FFF));
            1: r = ($urandom_range(0, 1) == 0) ? 20'hB7FFF : 20'hBC000;
            2: r = 20'h003D0 + 20'($urandom_range(0, 15));
            default: r = ($urandom_range(0, 1) == 0) ? 20'h003CF : 20'h003E0;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; a = '0; d = '0; memw = 1'b0; iow = 1'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_is_io", out_is_io, 0);
        tick();
        rst = 1'b0;
        tick();

        // single memory write, latency pinned
        a = 20'hB8000; d = 8'h41; memw = 1'b1;
        tick(); chk("lat_e0", out_valid, 0);
        tick(); chk("lat_e1", out_valid, 0);
        tick(); chk("lat_e2", out_valid, 1);
        chk("sw_addr", out_addr, 20'hB8000);
        chk("sw_data", out_data, 8'h41);
        chk("sw_is_io", out_is_io, 0);
        tick(); memw = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("sw_pop", level, 0);

        // I/O window
        write_pulse(1'b0, 1'b1, 20'h003D4, 8'h0F, 2);
        chk("io_level", level, 1);
        chk("io_is_io", out_is_io, 1);
        chk("io_data", out_data, 8'h0F);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        write_pulse(1'b0, 1'b1, 20'h003F8, 8'h55, 2);
        chk("io_filt", level, 0);
        chk("io_flag_ov", overflow, 0);
        chk("io_flag_col", collision, 0);

        // fill and overflow
        for (int i = 0; i < 9; i++) begin
            write_pulse(1'b1, 1'b0, 20'hB8000 + 20'(i), 8'(i), 1);
            if (i == 5) chk("afull_ready", cpu_ready, 0);
        end
        chk("full_level", level, 8);
        chk("full_ov", overflow, 1);
        chk("full_head", out_data, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_ov", overflow, 0);

        // push and pop in the same cycle while full
        a = 20'hB8008; d = 8'h08; memw = 1'b1;
        tick(); tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0; memw = 1'b0;
        chk("pp_level", level, 8);
        chk("pp_ov", overflow, 0);
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) begin
            chk("order", out_data, i);
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        chk("drained", level, 0);

        // collision
        write_pulse(1'b1, 1'b1, 20'hB8002, 8'h5A, 2);
        chk("col_level", level, 1);
        chk("col_is_io", out_is_io, 0);
        chk("col_flag", collision, 1);
        out_ready = 1'b1; clr_err = 1'b1; tick(); out_ready = 1'b0; clr_err = 1'b0;
        chk("col_clr", collision, 0);

        // held strobe and reset with strobe high
        write_pulse(1'b1, 1'b0, 20'hB8100, 8'hA1, 1);
        write_pulse(1'b1, 1'b0, 20'hB8101, 8'hA2, 1);
        a = 20'hB8010; d = 8'hC3; memw = 1'b1;
        repeat (50) tick();
        chk("held_level", level, 3);
        rst = 1'b1; tick(); tick();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", cpu_ready, 1);
        rst = 1'b0;
        repeat (6) tick();
        chk("rel_level", level, 1);
        memw = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // random traffic
        rand_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int kind;
            int ak;
            kind = $urandom_range(0, 19);
            ak   = $urandom_range(0, 9);
            if (kind == 19) begin
                rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
            end else if (kind < 11) begin
                write_pulse(1'b1, 1'b0, pick_addr(ak < 7 ? 0 : (ak < 8 ? 1 : 2)),
                            8'($urandom), $urandom_range(1, 6));
            end else if (kind < 17) begin
                write_pulse(1'b0, 1'b1, pick_addr(ak < 7 ? 2 : (ak < 8 ? 3 : 0)),
                            8'($urandom), $urandom_range(1, 6));
            end else begin
                write_pulse(1'b1, 1'b1, pick_addr(ak < 5 ? 0 : 2),
                            8'($urandom), $urandom_range(1, 6));
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1; clr_err = 1'b0;
        repeat (12) tick();
        chk("final_drain", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
